// File: rtl/bridge_pkg.sv
// Shared types and helpers for the M-stage memory bus bridge: align codes,
// FSM states, byte-enable constants, store lane replication and load extension.
package bridge_pkg;

  typedef enum logic [2:0] {
    AL_WORD  = 3'd0,
    AL_HALF  = 3'd1,
    AL_BYTE  = 3'd2,
    AL_HALFU = 3'd3,
    AL_BYTEU = 3'd4
  } align_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic [3:0] byte_enable(input logic [2:0] align, input logic [1:0] addr);
    logic [3:0] be;
    case (align)
      AL_HALF, AL_HALFU: be = addr[1] ? BE_HALF_HI : BE_HALF_LO;
      AL_BYTE, AL_BYTEU: be = BE_BYTE0 << addr;
      default:           be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] align, input logic [31:0] wd);
    logic [31:0] lanes;
    case (align)
      AL_HALF, AL_HALFU: lanes = {2{wd[15:0]}};
      AL_BYTE, AL_BYTEU: lanes = {4{wd[7:0]}};
      default:           lanes = wd;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] read_extend(input logic [2:0] align, input logic [1:0] addr,
                                              input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] ext;
    half = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    case (align)
      AL_HALF:  ext = {{16{half[15]}}, half};
      AL_HALFU: ext = {16'h0000, half};
      AL_BYTE:  ext = {{24{byte_v[7]}}, byte_v};
      AL_BYTEU: ext = {24'h00_0000, byte_v};
      default:  ext = word;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/bridge_decoder.sv
// Combinational address decoder: window hits, lowest-index slave select and
// the combined address-error term (alignment, range, width, read-only, overflow).
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int                   N_SLV         = 4,
  parameter logic [N_SLV*32-1:0]  SLV_BASE      = {32'h7f20, 32'h7f10, 32'h7f00, 32'h0},
  parameter logic [N_SLV*32-1:0]  SLV_LIMIT     = {32'h7f23, 32'h7f1b, 32'h7f0b, 32'h2fff},
  parameter logic [N_SLV-1:0]     SLV_WORD_ONLY = 4'b0110,
  parameter logic [31:0]          RO_ADDR0      = 32'h7f08,
  parameter logic [31:0]          RO_ADDR1      = 32'h7f18
) (
  input  logic             cpu_we,
  input  logic [2:0]       cpu_align,
  input  logic [31:0]      cpu_addr,
  input  logic             exc_ov,
  output logic [N_SLV-1:0] sel,
  output logic             err
);

  logic [N_SLV-1:0] hit;
  logic             misalign;
  logic             width_err;
  logic             ro_err;

  always_comb begin
    hit = {N_SLV{1'b0}};
    for (int i = 0; i < N_SLV; i++) begin
      hit[i] = (cpu_addr >= SLV_BASE[i*32 +: 32]) && (cpu_addr <= SLV_LIMIT[i*32 +: 32]);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  assign sel = hit & (~hit + N_SLV'(1));

  always_comb begin
    case (cpu_align)
      AL_WORD:           misalign = (cpu_addr[1:0] != 2'b00);
      AL_HALF, AL_HALFU: misalign = cpu_addr[0];
      default:           misalign = 1'b0;
    endcase
  end

  assign width_err = (cpu_align != AL_WORD) && ((sel & SLV_WORD_ONLY) != {N_SLV{1'b0}});
  assign ro_err    = cpu_we && ((cpu_addr == RO_ADDR0) || (cpu_addr == RO_ADDR1));
  assign err       = misalign || (hit == {N_SLV{1'b0}}) || width_err || ro_err || exc_ov;

endmodule

// File: rtl/mem_bus_bridge.sv
// CPU-to-peripheral bridge top: FSM, request registers, lane shifting and read extension.
// Optional BUSY timeout is compiled in with `define BRIDGE_TIMEOUT_EN.
module mem_bus_bridge
  import bridge_pkg::*;
#(
  parameter int                   N_SLV         = 4,
  parameter logic [N_SLV*32-1:0]  SLV_BASE      = {32'h7f20, 32'h7f10, 32'h7f00, 32'h0},
  parameter logic [N_SLV*32-1:0]  SLV_LIMIT     = {32'h7f23, 32'h7f1b, 32'h7f0b, 32'h2fff},
  parameter logic [N_SLV-1:0]     SLV_WORD_ONLY = 4'b0110,
  parameter logic [31:0]          RO_ADDR0      = 32'h7f08,
  parameter logic [31:0]          RO_ADDR1      = 32'h7f18
`ifdef BRIDGE_TIMEOUT_EN
  ,
  parameter int                   TIMEOUT_CYC   = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                exc_ov,
  input  logic                cpu_valid,
  input  logic                cpu_we,
  input  logic [2:0]          cpu_align,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wd,
  input  logic [31:0]         cpu_pc,
  output logic                cpu_stall,
  output logic [31:0]         cpu_rd,
  output logic                cpu_rd_valid,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic                bus_err,
  output logic [N_SLV-1:0]    s_valid,
  input  logic [N_SLV-1:0]    s_ready,
  output logic [31:0]         s_addr,
  output logic [31:0]         s_wd,
  output logic [3:0]          s_byteen,
  input  logic [N_SLV*32-1:0] s_rd,
  output logic [31:0]         m_inst_addr
);

  state_t           state, next_state;
  logic [N_SLV-1:0] sel, slot;
  logic             err, accept, busy, ready_sel, tmo_hit, abort;
  logic [2:0]       align_q;
  logic [31:0]      rd_sel;

  bridge_decoder #(
    .N_SLV(N_SLV), .SLV_BASE(SLV_BASE), .SLV_LIMIT(SLV_LIMIT),
    .SLV_WORD_ONLY(SLV_WORD_ONLY), .RO_ADDR0(RO_ADDR0), .RO_ADDR1(RO_ADDR1)
  ) u_dec (
    .cpu_we(cpu_we), .cpu_align(cpu_align), .cpu_addr(cpu_addr),
    .exc_ov(exc_ov), .sel(sel), .err(err)
  );

  assign busy      = (state == ST_BUSY);
  assign accept    = (state == ST_IDLE) && cpu_valid && !err && !req;
  assign cpu_stall = accept || busy;
  assign exc_adel  = (state == ST_IDLE) && cpu_valid && !cpu_we && err;
  assign exc_ades  = (state == ST_IDLE) && cpu_valid && cpu_we && err;
  assign ready_sel = ((s_ready & slot) != {N_SLV{1'b0}}) && !tmo_hit;

`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counts BUSY cycles; restarts on every accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= 16'd0;
    end else if (accept) begin
      tmo_cnt <= 16'd0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  assign tmo_hit = busy && (tmo_cnt == 16'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  // One-hot read data mux onto the latched slot.
  always_comb begin
    rd_sel = 32'h0000_0000;
    for (int i = 0; i < N_SLV; i++) begin
      rd_sel = rd_sel | (s_rd[i*32 +: 32] & {32{slot[i]}});
    end
  end

  // Request strobe to the selected slave for as long as the bridge waits.
  always_comb begin
    s_valid = {N_SLV{1'b0}};
    if (busy && !tmo_hit) begin
      s_valid = slot;
    end else begin
      s_valid = {N_SLV{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: next_state = accept ? ST_BUSY : ST_IDLE;
      ST_BUSY: next_state = (ready_sel || tmo_hit) ? ST_DONE : ST_BUSY;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request latch, abort tracking and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot         <= {N_SLV{1'b0}};
      s_addr       <= 32'h0000_0000;
      s_wd         <= 32'h0000_0000;
      s_byteen     <= 4'b0000;
      align_q      <= 3'd0;
      m_inst_addr  <= 32'h0000_0000;
      abort        <= 1'b0;
      cpu_rd       <= 32'h0000_0000;
      cpu_rd_valid <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      if (accept) begin
        slot        <= sel;
        s_addr      <= cpu_addr;
        s_wd        <= store_lanes(cpu_align, cpu_wd);
        s_byteen    <= cpu_we ? byte_enable(cpu_align, cpu_addr[1:0]) : 4'b0000;
        align_q     <= cpu_align;
        m_inst_addr <= cpu_pc;
        abort       <= 1'b0;
      end else if (busy && req) begin
        abort <= 1'b1;
      end else begin
        abort <= abort;
      end
      if (tmo_hit) begin
        cpu_rd <= 32'h0000_0000;
      end else if (busy && ready_sel) begin
        cpu_rd <= read_extend(align_q, s_addr[1:0], rd_sel);
      end else begin
        cpu_rd <= cpu_rd;
      end
      // A flush arriving on the ready cycle must also suppress the strobe.
      cpu_rd_valid <= busy && ready_sel && !abort && !req;
      bus_err      <= tmo_hit;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed self-checking bench for mem_bus_bridge (default build, timeout disabled).
module tb_mem_bus_bridge;
  logic         clk = 1'b0;
  logic         reset, req, exc_ov, cpu_valid, cpu_we;
  logic [2:0]   cpu_align;
  logic [31:0]  cpu_addr, cpu_wd, cpu_pc;
  logic         cpu_stall, cpu_rd_valid, exc_adel, exc_ades, bus_err;
  logic [31:0]  cpu_rd, s_addr, s_wd, m_inst_addr;
  logic [3:0]   s_valid, s_ready, s_byteen;
  logic [127:0] s_rd;
  int           vectors = 0;
  int           miscompares = 0;

  mem_bus_bridge dut (
    .clk(clk), .reset(reset), .req(req), .exc_ov(exc_ov), .cpu_valid(cpu_valid),
    .cpu_we(cpu_we), .cpu_align(cpu_align), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_rd(cpu_rd), .cpu_rd_valid(cpu_rd_valid),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err), .s_valid(s_valid),
    .s_ready(s_ready), .s_addr(s_addr), .s_wd(s_wd), .s_byteen(s_byteen), .s_rd(s_rd),
    .m_inst_addr(m_inst_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single access with zero-wait slave; returns what was seen at each step.
  task automatic run_access(input logic we, input logic [2:0] al, input logic [31:0] addr,
                            input logic [31:0] wd, input int slot_idx,
                            output logic stall_acc, output logic [3:0] be,
                            output logic [31:0] wdo, output logic [3:0] sv,
                            output logic [31:0] rd, output logic rdv);
    tick();
    cpu_valid = 1'b1; cpu_we = we; cpu_align = al; cpu_addr = addr; cpu_wd = wd;
    cpu_pc = 32'h0040_0000 + addr;
    #1 stall_acc = cpu_stall;
    tick();
    cpu_valid = 1'b0;
    #1 be = s_byteen; wdo = s_wd; sv = s_valid;
    s_ready[slot_idx] = 1'b1;
    tick();
    s_ready = 4'b0000;
    #1 rd = cpu_rd; rdv = cpu_rd_valid;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; exc_ov = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;
    cpu_align = 3'd0; cpu_addr = 32'h0; cpu_wd = 32'h0; cpu_pc = 32'h0;
    s_ready = 4'b0000; s_rd = 128'h0;
    tick(); tick();
    vectors++;
    if ({cpu_stall, cpu_rd_valid, exc_adel, exc_ades, bus_err, s_valid, s_byteen} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {cpu_stall, cpu_rd_valid, exc_adel, exc_ades, bus_err, s_valid, s_byteen});
    end
    vectors++;
    if ({cpu_rd, s_addr, s_wd, m_inst_addr} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {cpu_rd, s_addr, s_wd, m_inst_addr});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_lw_wait;
    int stalls = 0;
    int svc = 0;
    s_rd[31:0] = 32'h1234_5678;
    tick();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_align = 3'd0; cpu_addr = 32'h4; cpu_pc = 32'h0040_0100;
    #1 if (cpu_stall) stalls++;
    tick();
    cpu_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) s_ready[0] = 1'b1;
      #1 if (cpu_stall) stalls++;
      if (s_valid == 4'b0001) svc++;
      tick();
    end
    s_ready = 4'b0000;
    #1;
    vectors++;
    if (stalls != 4 || svc != 3) begin
      miscompares++;
      $display("FAIL lw_wait_cycles: stall %0d sval %0d want 4 3", stalls, svc);
    end
    vectors++;
    if (cpu_rd_valid !== 1'b1 || cpu_rd !== 32'h1234_5678 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_wait_data: got v%b %h st%b want v1 12345678 st0", cpu_rd_valid, cpu_rd, cpu_stall);
    end
    vectors++;
    if (m_inst_addr !== 32'h0040_0100 || s_addr !== 32'h4 || s_byteen !== 4'b0000) begin
      miscompares++;
      $display("FAIL lw_wait_regs: got pc %h a %h be %b", m_inst_addr, s_addr, s_byteen);
    end
    tick();
    vectors++;
    if (cpu_rd_valid !== 1'b0 || s_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL lw_wait_strobe: got v%b sv %b want 0 0000", cpu_rd_valid, s_valid);
    end
  endtask

  task automatic test_stores;
    logic st; logic [3:0] be, sv; logic [31:0] wdo, rd; logic rdv;
    run_access(1'b1, 3'd2, 32'h7f21, 32'h0000_00AB, 3, st, be, wdo, sv, rd, rdv);
    vectors++;
    if (st !== 1'b1 || be !== 4'b0010 || wdo[15:8] !== 8'hAB || sv !== 4'b1000 || rdv !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_7f21: got st%b be %b wd %h sv %b v%b", st, be, wdo, sv, rdv);
    end
    run_access(1'b1, 3'd1, 32'h0000_0002, 32'hCAFE_1234, 0, st, be, wdo, sv, rd, rdv);
    vectors++;
    if (be !== 4'b1100 || wdo !== 32'h1234_1234 || sv !== 4'b0001) begin
      miscompares++;
      $display("FAIL sh_0002: got be %b wd %h sv %b want 1100 12341234 0001", be, wdo, sv);
    end
    run_access(1'b1, 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 0, st, be, wdo, sv, rd, rdv);
    vectors++;
    if (be !== 4'b1111 || wdo !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL sw_0010: got be %b wd %h want 1111 deadbeef", be, wdo);
    end
  endtask

  task automatic test_extend;
    logic st; logic [3:0] be, sv; logic [31:0] wdo, rd; logic rdv;
    logic [2:0]  al  [5] = '{3'd4, 3'd2, 3'd3, 3'd1, 3'd2};
    logic [31:0] ad  [5] = '{32'h3, 32'h3, 32'h2, 32'h2, 32'h1};
    logic [31:0] exp [5] = '{32'h0000_0080, 32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_0000};
    s_rd[31:0] = 32'h80FF_0000;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, al[i], ad[i], 32'h0, 0, st, be, wdo, sv, rd, rdv);
      vectors++;
      if (rd !== exp[i] || rdv !== 1'b1 || be !== 4'b0000) begin
        miscompares++;
        $display("FAIL extend_%0d: got %h v%b be %b want %h v1 0000", i, rd, rdv, be, exp[i]);
      end
    end
    s_rd[63:32] = 32'h5A5A_0001;
    run_access(1'b0, 3'd0, 32'h7f08, 32'h0, 1, st, be, wdo, sv, rd, rdv);
    vectors++;
    if (st !== 1'b1 || sv !== 4'b0010 || rd !== 32'h5A5A_0001 || rdv !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_ro_read: got st%b sv %b rd %h v%b", st, sv, rd, rdv);
    end
  endtask

  task automatic test_errors;
    logic        we  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  al  [7] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [31:0] ad  [7] = '{32'h7f08, 32'h7f00, 32'h3000, 32'h2, 32'h7f21, 32'h7f0c, 32'h4};
    logic        ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      tick();
      cpu_valid = 1'b1; cpu_we = we[i]; cpu_align = al[i]; cpu_addr = ad[i]; exc_ov = ov[i];
      #1;
      vectors++;
      if (exc_ades !== we[i] || exc_adel !== !we[i] || cpu_stall !== 1'b0 || s_valid !== 4'b0000) begin
        miscompares++;
        $display("FAIL err_%0d: got es%b el%b st%b sv %b want es%b el%b st0 sv0", i, exc_ades, exc_adel, cpu_stall, s_valid, we[i], !we[i]);
      end
      tick();
      cpu_valid = 1'b0; exc_ov = 1'b0;
      #1;
      vectors++;
      if (s_valid !== 4'b0000 || cpu_stall !== 1'b0 || exc_adel !== 1'b0 || exc_ades !== 1'b0) begin
        miscompares++;
        $display("FAIL err_idle_%0d: got sv %b st%b el%b es%b want 0", i, s_valid, cpu_stall, exc_adel, exc_ades);
      end
    end
    tick();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_align = 3'd0; cpu_addr = 32'h8; req = 1'b1;
    #1;
    vectors++;
    if (cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL req_idle_stall: got %b want 0", cpu_stall);
    end
    tick();
    cpu_valid = 1'b0; req = 1'b0;
    #1;
    vectors++;
    if (s_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL req_idle_sval: got %b want 0000", s_valid);
    end
  endtask

  task automatic test_abort;
    logic st; logic [3:0] be, sv; logic [31:0] wdo, rd; logic rdv;
    s_rd[31:0] = 32'h0BAD_F00D;
    tick();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_align = 3'd0; cpu_addr = 32'h8;
    tick();
    cpu_valid = 1'b0; req = 1'b1;
    tick();
    req = 1'b0; s_ready[0] = 1'b1;
    #1;
    vectors++;
    if (s_valid !== 4'b0001 || cpu_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_handshake: got sv %b st%b want 0001 1", s_valid, cpu_stall);
    end
    tick();
    s_ready = 4'b0000;
    vectors++;
    if (cpu_rd_valid !== 1'b0 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_rdvalid: got v%b st%b want 0 0", cpu_rd_valid, cpu_stall);
    end
    // Flush landing on the ready cycle itself.
    tick();
    cpu_valid = 1'b1; cpu_addr = 32'hC;
    tick();
    cpu_valid = 1'b0; req = 1'b1; s_ready[0] = 1'b1;
    tick();
    req = 1'b0; s_ready = 4'b0000;
    vectors++;
    if (cpu_rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_on_ready: got %b want 0", cpu_rd_valid);
    end
    run_access(1'b0, 3'd0, 32'h10, 32'h0, 0, st, be, wdo, sv, rd, rdv);
    vectors++;
    if (rdv !== 1'b1 || rd !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL after_abort: got v%b %h want v1 0badf00d", rdv, rd);
    end
  endtask

  task automatic test_reset_busy;
    tick();
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_align = 3'd0; cpu_addr = 32'h7f20;
    tick();
    cpu_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (s_valid !== 4'b0000 || cpu_stall !== 1'b0 || m_inst_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_busy: got sv %b st%b pc %h want 0", s_valid, cpu_stall, m_inst_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (s_valid !== 4'b0000 || cpu_rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_after: got sv %b v%b want 0", s_valid, cpu_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_stores();
    test_extend();
    test_errors();
    test_abort();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
